program_sequencer: RTL

// - Consumes the assembler's 32-bit inst word and store_clk write strobe.
// - In program mode it captures instructions into an on-chip program buffer.
// - In run mode it replays the buffer to the execute stage over a valid/ready handshake.
// - Resolves JUMP instructions internally by reloading its program counter.
// - Sits directly downstream of the assembler, upstream of the video execute unit.

---
 rtl/vdp_pkg.sv | 13 +
 rtl/program_sequencer_strobe_sync.sv | 13 +
 rtl/program_sequencer.sv | 88 ++++++++
 3 files changed

// File: rtl/vdp_pkg.sv
// vdp_pkg: shared opcode, field-position and FSM-state constants for the video datapath.
package vdp_pkg;
  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_JUMP = 2'b10;
  localparam int OP_HI  = 31;
  localparam int OP_LO  = 30;
  localparam int VAL_HI = 15;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;
endpackage

// File: rtl/program_sequencer_strobe_sync.sv
// strobe_sync: two-flop synchroniser for an asynchronous strobe plus a rising-edge pulse.
module strobe_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe,
  output logic pulse
);
  logic [2:0] s;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s <= '0;
    else s <= {s[1:0], strobe};
  assign pulse = s[1] & ~s[2];
endmodule

// File: rtl/program_sequencer.sv
// program_sequencer: captures assembler words into a program buffer and replays them
// to the execute stage over valid/ready, resolving JUMPs internally.
module program_sequencer import vdp_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          prog,
  input  logic [31:0]   inst,
  input  logic          store_clk,
  input  logic          run_start,
  output logic [31:0]   out_inst,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   prog_len,
  output logic          full,
  output logic          overflow,
  output logic          jump_err,
  output logic          done
);
  logic [1:0]    state;
  logic [AW:0]   wr_ptr;
  logic [AW-1:0] pc;
  logic [31:0]   mem [DEPTH];
  logic          wr_pulse;
  strobe_sync u_sync (.clk(clk), .rst_n(rst_n), .strobe(store_clk), .pulse(wr_pulse));
  assign prog_len = wr_ptr;
  assign full     = wr_ptr == (AW+1)'(DEPTH);
  assign done     = state == S_HALT;
  logic          is_jump, jump_ok, last;
  logic [AW-1:0] target;
  assign is_jump = out_inst[OP_HI:OP_LO] == OP_JUMP;
  assign target  = out_inst[AW-1:0];
  assign jump_ok = ({1'b0, target} < wr_ptr) && (out_inst[VAL_HI:AW] == '0);
  assign last    = ({1'b0, pc} + 1'b1) == wr_ptr;
  always_ff @(posedge clk)
    if (state == S_LOAD && wr_pulse && !full) mem[wr_ptr[AW-1:0]] <= inst;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      pc        <= '0;
      out_inst  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      jump_err  <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (wr_pulse && full) overflow <= 1'b1;
          else if (wr_pulse) wr_ptr <= wr_ptr + 1'b1;
          if (!prog) state <= S_IDLE;
        end
        S_RUN: begin
          if (prog) begin
            state     <= S_LOAD;
            out_valid <= 1'b0;
            wr_ptr    <= '0;
            overflow  <= 1'b0;
          end else if (!out_valid) begin
            out_valid <= 1'b1;
            out_inst  <= mem[pc];
          end else if (out_ready) begin
            // each accepted word leaves one bubble cycle while the next word is read
            out_valid <= 1'b0;
            if (is_jump && jump_ok) pc <= target;
            else if (is_jump) begin
              jump_err <= 1'b1;
              state    <= S_HALT;
            end else if (last) state <= S_HALT;
            else pc <= pc + 1'b1;
          end
        end
        default: begin
          if (prog) begin
            state    <= S_LOAD;
            wr_ptr   <= '0;
            overflow <= 1'b0;
          end else if (run_start && wr_ptr != '0) begin
            state    <= S_RUN;
            pc       <= '0;
            jump_err <= 1'b0;
          end
        end
      endcase
    end
endmodule
